zipocpu_fetch: RTL and testbench

ZIPOCPU_FETCH -- requirements
Module: zipocpu_fetch

---
 rtl/zipocpu_pkg.sv | 25 ++
 rtl/zipocpu_fifo.sv | 57 +++++
 rtl/zipocpu_fetch.sv | 160 ++++++++++++++++
 tb/tb_zipocpu_fetch.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/zipocpu_pkg.sv
// zipocpu_pkg: shared definitions for the instruction fetch unit.
//   fetch_state_e      - fetch FSM states (FETCH, WAIT, DROP)
//   RV_OP / RV_OP_32   - RISC-V register-register ALU major opcodes
//   DEFAULT_XLEN       - default address/PC width
//   DEFAULT_INITIAL_PC - default first fetch address
//   is_alu_op()        - true when an instruction word carries an ALU opcode
package zipocpu_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } fetch_state_e;

    localparam logic [6:0] RV_OP    = 7'b0110011;
    localparam logic [6:0] RV_OP_32 = 7'b0111011;

    localparam int unsigned DEFAULT_XLEN       = 64;
    localparam logic [63:0] DEFAULT_INITIAL_PC = 64'h0000_0000_0000_0200;

    function automatic logic is_alu_op(input logic [31:0] insn);
        return (insn[6:0] == RV_OP) || (insn[6:0] == RV_OP_32);
    endfunction

endpackage

// File: rtl/zipocpu_fifo.sv
// zipocpu_fifo: prefetch queue, power-of-two depth, first-word-fall-through.
//   clk, rst_n    - clock, asynchronous active-low reset
//   flush_i       - synchronous clear; wins over push_i/pop_i
//   push_i        - write push_data_i at the tail (caller guarantees not full)
//   push_data_i   - entry to store
//   pop_i         - drop the head entry (caller guarantees not empty)
//   head_o        - current head entry, stable until popped
//   valid_o       - queue not empty
//   count_o       - number of stored entries, 0..DEPTH
module zipocpu_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    // Storage needs no reset: contents are only observed behind valid_o.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/zipocpu_fetch.sv
// zipocpu_fetch: instruction fetch unit with a single outstanding memory
// request, a prefetch queue and branch/jump redirect handling.
//   clk, rst_n              - clock, asynchronous active-low reset
//   mem_req/mem_addr        - instruction read request (held until mem_ack)
//   mem_ack/mem_rdata       - request accepted, instruction word this cycle
//   redir_valid/redir_pc    - redirect the fetch stream (word-aligned)
//   inst_valid/inst_ready   - head-of-queue handshake to the consumer
//   inst_data/inst_pc       - head instruction and its address
//   inst_is_alu             - head has an OP or OP-32 opcode
// Optional (macro ZIPOCPU_FETCH_PERF_EN):
//   perf_retired            - wrapping count of consumed instructions
//   perf_flushed            - wrapping count of redirects
module zipocpu_fetch
    import zipocpu_pkg::*;
#(
    parameter int unsigned      XLEN       = DEFAULT_XLEN,
    parameter logic [XLEN-1:0]  INITIAL_PC = XLEN'(DEFAULT_INITIAL_PC),
    parameter int unsigned      FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             mem_req,
    output logic [XLEN-1:0]  mem_addr,
    input  logic             mem_ack,
    input  logic [31:0]      mem_rdata,
    input  logic             redir_valid,
    input  logic [XLEN-1:0]  redir_pc,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [31:0]      inst_data,
    output logic [XLEN-1:0]  inst_pc,
    output logic             inst_is_alu
`ifdef ZIPOCPU_FETCH_PERF_EN
   ,output logic [31:0]      perf_retired
   ,output logic [31:0]      perf_flushed
`endif
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] pc_q, pc_d;

    logic             push, pop;
    logic [CW-1:0]    count, count_after;
    logic [XLEN+31:0] head;
    logic [XLEN-1:0]  redir_tgt, addr_next;
    logic             redir_lsb_unused;

    assign redir_tgt        = {redir_pc[XLEN-1:2], 2'b00};
    assign redir_lsb_unused = ^redir_pc[1:0];
    assign addr_next        = addr_q + XLEN'(4);

    // A redirect kills the consumer handshake as well as the queue.
    assign pop         = inst_valid & inst_ready & ~redir_valid;
    assign count_after = count + CW'(1) - CW'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            req_q   <= 1'b0;
            addr_q  <= INITIAL_PC;
            pc_q    <= INITIAL_PC;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            pc_q    <= pc_d;
        end
    end

    // pc_q is the next address to request; in DROP it is the pending
    // redirect target while the stale request is still outstanding.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        pc_d    = pc_q;
        push    = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (redir_valid) begin
                    pc_d    = redir_tgt;
                    addr_d  = redir_tgt;
                    req_d   = 1'b1;
                    state_d = WAIT;
                end else if (count < CW'(FIFO_DEPTH)) begin
                    addr_d  = pc_q;
                    req_d   = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redir_valid) begin
                    pc_d = redir_tgt;
                    if (mem_ack) addr_d  = redir_tgt;
                    else         state_d = DROP;
                end else if (mem_ack) begin
                    push = 1'b1;
                    pc_d = addr_next;
                    if (count_after < CW'(FIFO_DEPTH)) begin
                        addr_d = addr_next;
                    end else begin
                        req_d   = 1'b0;
                        state_d = FETCH;
                    end
                end
            end
            DROP: begin
                if (redir_valid) pc_d = redir_tgt;
                if (mem_ack) begin
                    addr_d  = redir_valid ? redir_tgt : pc_q;
                    state_d = WAIT;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    zipocpu_fifo #(
        .WIDTH (XLEN + 32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (redir_valid),
        .push_i      (push),
        .push_data_i ({mem_rdata, addr_q}),
        .pop_i       (pop),
        .head_o      (head),
        .valid_o     (inst_valid),
        .count_o     (count)
    );

    assign mem_req     = req_q;
    assign mem_addr    = addr_q;
    assign inst_data   = head[XLEN+31:XLEN];
    assign inst_pc     = head[XLEN-1:0];
    assign inst_is_alu = is_alu_op(inst_data);

`ifdef ZIPOCPU_FETCH_PERF_EN
    logic [31:0] retired_q, flushed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
            flushed_q <= '0;
        end else begin
            retired_q <= retired_q + 32'(pop);
            flushed_q <= flushed_q + 32'(redir_valid);
        end
    end

    assign perf_retired = retired_q;
    assign perf_flushed = flushed_q;
`endif

endmodule

// File: tb/tb_zipocpu_fetch.sv
module tb_zipocpu_fetch;

    localparam logic [63:0] IPC = 64'h0000_0000_0000_0200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        redir_valid = 1'b0;
    logic [63:0] redir_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [63:0] inst_pc;
    logic        inst_is_alu;
`ifdef ZIPOCPU_FETCH_PERF_EN
    logic [31:0] perf_retired;
    logic [31:0] perf_flushed;
`endif

    zipocpu_fetch #(
        .XLEN       (64),
        .INITIAL_PC (IPC),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_data   (inst_data),
        .inst_pc     (inst_pc),
        .inst_is_alu (inst_is_alu)
`ifdef ZIPOCPU_FETCH_PERF_EN
       ,.perf_retired (perf_retired)
       ,.perf_flushed (perf_flushed)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] data;
        logic        alu;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_push(input logic [63:0] pc, input logic [31:0] data, input logic alu);
        exp_t e;
        e.pc   = pc;
        e.data = data;
        e.alu  = alu;
        sb.push_back(e);
    endtask

    // Apply inputs for the next rising edge, then move to 2 ns past it.
    task automatic drive(input logic ack, input logic [31:0] d, input logic rdy,
                         input logic rv, input logic [63:0] rpc);
        mem_ack     = ack;
        mem_rdata   = d;
        inst_ready  = rdy;
        redir_valid = rv;
        redir_pc    = rpc;
        @(posedge clk);
        #2;
    endtask

    task automatic reset_pulse();
        chk("sb_drained", 64'(sb.size()), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_async_req",   64'(mem_req),    64'd0);
        chk("rst_async_valid", 64'(inst_valid), 64'd0);
        chk("rst_async_addr",  mem_addr,        IPC);
`ifdef ZIPOCPU_FETCH_PERF_EN
        chk("rst_perf_retired", 64'(perf_retired), 64'd0);
        chk("rst_perf_flushed", 64'(perf_flushed), 64'd0);
`endif
        @(posedge clk);
        #2;
        chk("rst_hold_req", 64'(mem_req), 64'd0);
        rst_n = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        chk("rst_rel_req",  64'(mem_req), 64'd1);
        chk("rst_rel_addr", mem_addr,     IPC);
    endtask

    // Scoreboard monitor: every accepted head must match the oldest expectation.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n && inst_valid && inst_ready && !redir_valid) begin
                exp_t e;
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got pc 0x%0h data 0x%0h, expected no delivery",
                             inst_pc, inst_data);
                end else begin
                    e = sb.pop_front();
                    chk("sb_pc",   inst_pc,             e.pc);
                    chk("sb_data", 64'(inst_data),      64'(e.data));
                    chk("sb_alu",  64'(inst_is_alu),    64'(e.alu));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [63:0] b;
        logic [31:0] d;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        chk("reset_req",   64'(mem_req),    64'd0);
        chk("reset_valid", 64'(inst_valid), 64'd0);
        chk("reset_addr",  mem_addr,        IPC);
        rst_n = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        chk("first_req",  64'(mem_req), 64'd1);
        chk("first_addr", mem_addr,     IPC);

        // Streaming with ack always high
        expect_push(IPC, 32'h1111_0013, 1'b0);
        drive(1'b1, 32'h1111_0013, 1'b1, 1'b0, '0);
        chk("stream_valid0", 64'(inst_valid), 64'd1);
        chk("stream_addr1",  mem_addr,        IPC + 64'd4);
        expect_push(IPC + 64'd4, 32'h2222_0013, 1'b0);
        drive(1'b1, 32'h2222_0013, 1'b1, 1'b0, '0);
        chk("stream_valid1", 64'(inst_valid), 64'd1);
        chk("stream_addr2",  mem_addr,        IPC + 64'd8);
        expect_push(IPC + 64'd8, 32'h3333_0013, 1'b0);
        drive(1'b1, 32'h3333_0013, 1'b1, 1'b0, '0);
        chk("stream_valid2", 64'(inst_valid), 64'd1);

        // ALU opcode decode
        expect_push(IPC + 64'd12, 32'h00B5_0533, 1'b1);
        drive(1'b1, 32'h00B5_0533, 1'b1, 1'b0, '0);
        expect_push(IPC + 64'd16, 32'h0000_0013, 1'b0);
        drive(1'b1, 32'h0000_0013, 1'b1, 1'b0, '0);
        expect_push(IPC + 64'd20, 32'h0000_003B, 1'b1);
        drive(1'b1, 32'h0000_003B, 1'b1, 1'b0, '0);
        repeat (3) drive(1'b0, '0, 1'b1, 1'b0, '0);

        // Full queue back-pressure: exactly FIFO_DEPTH pushes
        b = IPC + 64'd24;
        for (int i = 0; i < 8; i++) begin
            d = {16'hC0DE, 8'(i), 8'h13};
            chk("full_req", 64'(mem_req), (i < 4) ? 64'd1 : 64'd0);
            if (i < 4) begin
                chk("full_addr", mem_addr, b + 64'(4 * i));
                expect_push(b + 64'(4 * i), d, 1'b0);
            end
            drive(1'b1, d, 1'b0, 1'b0, '0);
        end
        chk("full_hold_valid", 64'(inst_valid), 64'd1);
        chk("full_hold_pc",    inst_pc,         b);
        drive(1'b0, '0, 1'b1, 1'b0, '0);
        chk("pop_req_lag", 64'(mem_req), 64'd0);
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        chk("refill_req",  64'(mem_req), 64'd1);
        chk("refill_addr", mem_addr,     b + 64'd16);
        expect_push(b + 64'd16, 32'hC0DE_AA13, 1'b0);
        drive(1'b1, 32'hC0DE_AA13, 1'b0, 1'b0, '0);
        chk("refill_once0", 64'(mem_req), 64'd0);
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        chk("refill_once1", 64'(mem_req), 64'd0);
        repeat (5) drive(1'b0, '0, 1'b1, 1'b0, '0);

        // Redirect to a misaligned target while a request is pending
        drive(1'b0, '0, 1'b1, 1'b1, 64'h1003);
        chk("drop_req",   64'(mem_req),    64'd1);
        chk("drop_addr",  mem_addr,        b + 64'd20);
        chk("drop_valid", 64'(inst_valid), 64'd0);
        drive(1'b0, '0, 1'b1, 1'b0, '0);
        drive(1'b0, '0, 1'b1, 1'b0, '0);
        drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, '0);
        chk("redir_addr",  mem_addr,        64'h1000);
        chk("redir_req",   64'(mem_req),    64'd1);
        chk("redir_valid", 64'(inst_valid), 64'd0);
        expect_push(64'h1000, 32'h0000_1013, 1'b0);
        drive(1'b1, 32'h0000_1013, 1'b1, 1'b0, '0);
        chk("redir_first_pc", inst_pc, 64'h1000);
        drive(1'b0, '0, 1'b1, 1'b0, '0);

        // Redirect, ack and pop in the same cycle
        drive(1'b1, 32'hBAD0_0013, 1'b0, 1'b0, '0);
        chk("same_pre_valid", 64'(inst_valid), 64'd1);
        drive(1'b1, 32'hBAD1_0013, 1'b1, 1'b1, 64'h2000);
        chk("same_valid", 64'(inst_valid), 64'd0);
        chk("same_addr",  mem_addr,        64'h2000);
        chk("same_req",   64'(mem_req),    64'd1);
        drive(1'b0, '0, 1'b1, 1'b0, '0);
        chk("same_empty1", 64'(inst_valid), 64'd0);
        drive(1'b0, '0, 1'b1, 1'b0, '0);
        chk("same_empty2", 64'(inst_valid), 64'd0);
        expect_push(64'h2000, 32'h0000_2013, 1'b0);
        drive(1'b1, 32'h0000_2013, 1'b1, 1'b0, '0);
        chk("same_next_pc", inst_pc, 64'h2000);
        drive(1'b0, '0, 1'b1, 1'b0, '0);

        // Reset mid-request, then 10 pops and 2 redirects
        reset_pulse();
        for (int i = 0; i < 10; i++) begin
            d = {16'hBEEF, 8'(i), 8'h13};
            expect_push(IPC + 64'(4 * i), d, 1'b0);
            drive(1'b1, d, 1'b1, 1'b0, '0);
        end
        repeat (3) drive(1'b0, '0, 1'b1, 1'b0, '0);
        drive(1'b0, '0, 1'b1, 1'b1, 64'h3000);
        drive(1'b0, '0, 1'b1, 1'b1, 64'h3013);
        drive(1'b1, 32'hDEAD_0013, 1'b1, 1'b0, '0);
        chk("drop_latest_addr", mem_addr, 64'h3010);
`ifdef ZIPOCPU_FETCH_PERF_EN
        chk("perf_retired", 64'(perf_retired), 64'd10);
        chk("perf_flushed", 64'(perf_flushed), 64'd2);
`endif
        reset_pulse();

        chk("sb_final_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
